// File: rtl/serial_frame_rx.sv
// serial_frame_rx: bit-serial frame receiver.
// Frame = start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// Good frames update dout with a one-cycle dout_valid pulse. Bad frames give a
// one-cycle frame_err pulse and bump a saturating error counter.
// Optional parity stage is compiled in when SERIAL_RX_PARITY_EN is defined;
// the default build has no parity bit and PARITY_ODD is ignored.
`timescale 1ns/1ps

module serial_frame_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_ODD = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  frame_err,
    output logic                  busy,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 16 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("serial_frame_rx: illegal parameter value");
    end

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic [DATA_WIDTH-1:0]  shift_nxt;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
    logic                   frame_ok;
`ifdef SERIAL_RX_PARITY_EN
    logic                   par_ok_q, par_ok_d;
`endif

    // New bits enter at the MSB so that after DATA_WIDTH shifts the first
    // received bit sits at bit 0.
    if (DATA_WIDTH == 1) begin : g_shift_one
        assign shift_nxt = din;
    end else begin : g_shift_many
        assign shift_nxt = {din, shift_q[DATA_WIDTH-1:1]};
    end

    // A frame is accepted when the stop bit is 1 (and parity matched, if present).
`ifdef SERIAL_RX_PARITY_EN
    assign frame_ok = din & par_ok_q;
`else
    assign frame_ok = din;
`endif

    // Next-state and output decode for the receive FSM.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        err_count_d  = err_count_q;
`ifdef SERIAL_RX_PARITY_EN
        par_ok_d     = par_ok_q;
`endif
        case (state_q)
            IDLE: begin
                if (!din) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                shift_d = shift_nxt;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                // Parity bit is judged here so STOP only has to look at din.
                par_ok_d = (((^shift_q) ^ din) == (PARITY_ODD != 0));
                state_d  = STOP;
            end
`endif
            STOP: begin
                state_d = IDLE;
                if (frame_ok) begin
                    dout_d       = shift_q;
                    dout_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                    if (err_count_q != {ERR_CNT_W{1'b1}}) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            err_count_q  <= '0;
`ifdef SERIAL_RX_PARITY_EN
            par_ok_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            err_count_q  <= err_count_d;
`ifdef SERIAL_RX_PARITY_EN
            par_ok_q     <= par_ok_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: table-driven frames plus hand-written sequences,
// with a scoreboard queue of expected result pulses.
`timescale 1ns/1ps

module tb_serial_frame_rx;

    localparam int DW   = 8;
    localparam int PODD = 0;
    localparam int EW   = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int FRAME_LEN = DW + 2 + (PAR_EN ? 1 : 0);
    localparam int ERR_MAX   = (1 << EW) - 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          din   = 1'b1;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          frame_err;
    logic          busy;
    logic [EW-1:0] err_count;

    serial_frame_rx #(
        .DATA_WIDTH (DW),
        .PARITY_ODD (PODD),
        .ERR_CNT_W  (EW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .busy       (busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        bit            good;
        logic [DW-1:0] dout;
        logic [EW-1:0] errc;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        bit            par_flip;
        bit            stop;
        bit            exp_valid;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[6];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    int            last_v = -1;
    int            prev_v = -1;
    int            valid_count = 0;
    logic [DW-1:0] m_dout = '0;
    logic [EW-1:0] m_err  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: every result pulse must match the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (dout_valid || frame_err) begin
                    check("valid_err_exclusive", 32'(dout_valid & frame_err), 32'd0);
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("pulse_cycle", 32'(cyc), 32'(e.due));
                        check("pulse_kind_valid", 32'(dout_valid), 32'(e.good));
                        check("dout", 32'(dout), 32'(e.dout));
                        check("err_count", 32'(err_count), 32'(e.errc));
                    end
                    if (dout_valid) begin
                        prev_v = last_v;
                        last_v = cyc;
                        valid_count++;
                    end
                end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                    check("missing_pulse", 32'd0, 32'd1);
                    e = sb.pop_front();
                end
            end
        end
    end

    task automatic bit_out(input logic b);
        @(negedge clk);
        din = b;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) bit_out(1'b1);
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input bit par_flip, input bit stop,
                              input bit exp_good);
        logic p;
        bit_out(1'b0);
        for (int i = 0; i < DW; i++) begin
            bit_out(data[i]);
            if (i == 0) check("busy_in_frame", 32'(busy), 32'd1);
        end
        p = (^data) ^ (PODD != 0) ^ par_flip;
        if (PAR_EN) bit_out(p);
        bit_out(stop);
        if (exp_good) begin
            m_dout = data;
        end else if (m_err != {EW{1'b1}}) begin
            m_err = m_err + 1'b1;
        end
        sb.push_back('{due: cyc + 1, good: exp_good, dout: m_dout, errc: m_err});
    endtask

    initial begin
        int v0;
        vecs[0] = '{data: 8'hA5, par_flip: 1'b0, stop: 1'b1, exp_valid: 1'b1};
        vecs[1] = '{data: 8'h3C, par_flip: 1'b1, stop: 1'b1, exp_valid: !PAR_EN};
        vecs[2] = '{data: 8'h0F, par_flip: 1'b0, stop: 1'b0, exp_valid: 1'b0};
        vecs[3] = '{data: 8'h00, par_flip: 1'b0, stop: 1'b1, exp_valid: 1'b1};
        vecs[4] = '{data: 8'hFF, par_flip: 1'b0, stop: 1'b1, exp_valid: 1'b1};
        vecs[5] = '{data: 8'h81, par_flip: 1'b1, stop: 1'b0, exp_valid: 1'b0};

        // Reset state
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_bits(2);

        // Table of single frames
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop, vecs[i].exp_valid);
            idle_bits(2);
        end

        // Back-to-back frames, no idle between stop and next start
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
        idle_bits(3);
        check("b2b_spacing", 32'(last_v - prev_v), 32'(FRAME_LEN));
        check("b2b_dout", 32'(dout), 32'hFF);

        // Reset asserted after 3 data bits of a frame
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_dout_valid", 32'(dout_valid), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_err_count", 32'(err_count), 32'd0);
        m_dout = '0;
        m_err  = '0;
        @(negedge clk);
        din = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle_bits(2);
        v0 = valid_count;
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        idle_bits(3);
        check("after_rst_dout", 32'(dout), 32'h5A);
        check("after_rst_one_valid", 32'(valid_count - v0), 32'd1);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            send_frame(DW'($urandom), 1'b0, 1'b0, 1'b0);
        end
        idle_bits(3);
        check("err_saturated", 32'(err_count), 32'(ERR_MAX));
        check("dout_kept_after_errs", 32'(dout), 32'h5A);

        // Long idle stream
        v0 = valid_count;
        for (int i = 0; i < 50; i++) begin
            bit_out(1'b1);
            check("idle_busy", 32'(busy), 32'd0);
        end
        check("idle_no_valid", 32'(valid_count - v0), 32'd0);
        check("idle_err_count", 32'(err_count), 32'(ERR_MAX));
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
